xsw_lock_arb: RTL and testbench



---
 rtl/xsw_lock_arb.sv | 133 +++++++++++++
 tb/tb_xsw_lock_arb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/xsw_lock_arb.sv
// rtl/xsw_lock_arb.sv - round-robin output-slot arbiter with slot locking
// Optional lock timeout enabled by defining XSW_ARB_LOCK_TIMEOUT_EN.
module xsw_lock_arb #(
    parameter int N        = 4,
    parameter int LOCK_MAX = 15,
    parameter int TW       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         ocy,
    input  logic [N-1:0]         rel,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 locked,
    output logic [$clog2(N)-1:0] lock_owner,
    output logic                 to_pulse
);

    localparam int IW = $clog2(N);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt, owner_nxt;
    logic          timeout;
    logic          found;
    logic [IW-1:0] sel;
    int            jj;

    if (N < 2 || LOCK_MAX >= (1 << TW)) begin : g_bad_cfg
        $error("xsw_lock_arb: illegal N/LOCK_MAX/TW combination");
    end

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) == N - 1)
            return '0;
        else
            return i + 1'b1;
    endfunction

    // Grant is combinational so the mux select follows req in the same cycle.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sel     = '0;
        jj      = 0;
        if (!rst && en) begin
            if (state == LOCK) begin
                if (req[lock_owner] && !timeout) begin
                    gnt[lock_owner] = 1'b1;
                    gnt_idx         = lock_owner;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    jj = int'(ptr) + k;
                    if (jj >= N)
                        jj = jj - N;
                    sel = IW'(jj);
                    if (!found && req[sel]) begin
                        found    = 1'b1;
                        gnt[sel] = 1'b1;
                        gnt_idx  = sel;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = lock_owner;
        case (state)
            IDLE: begin
                if (|gnt) begin
                    ptr_nxt = next_idx(gnt_idx);
                    if (ocy[gnt_idx] && !rel[gnt_idx]) begin
                        state_nxt = LOCK;
                        owner_nxt = gnt_idx;
                    end
                end
            end
            LOCK: begin
                if (timeout || ((|gnt) && rel[lock_owner])) begin
                    state_nxt = IDLE;
                    ptr_nxt   = next_idx(lock_owner);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            lock_owner <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            lock_owner <= owner_nxt;
        end
    end

    assign locked = (state == LOCK);

`ifdef XSW_ARB_LOCK_TIMEOUT_EN
    logic [TW-1:0] to_cnt;

    assign timeout = (state == LOCK) && (to_cnt == TW'(LOCK_MAX));

    // Counter rests at zero outside LOCK, so lock entry always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt   <= '0;
            to_pulse <= 1'b0;
        end else begin
            to_pulse <= timeout;
            if (state == IDLE || timeout || (|gnt))
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout  = 1'b0;
    assign to_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_xsw_lock_arb.sv
// tb/tb_xsw_lock_arb.sv - directed table-driven bench for xsw_lock_arb
module tb_xsw_lock_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, ocy, rel;
    logic       en;
    logic [3:0] gnt;
    logic [1:0] gnt_idx, lock_owner;
    logic       locked, to_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xsw_lock_arb #(.N(4), .LOCK_MAX(15), .TW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ocy        (ocy),
        .rel        (rel),
        .en         (en),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .locked     (locked),
        .lock_owner (lock_owner),
        .to_pulse   (to_pulse)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] ocy;
        logic [3:0] rel;
        logic       en;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       locked;
        logic [1:0] owner;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_inv();
        logic [3:0] own_mask;
        own_mask = 4'b0001 << lock_owner;
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("gnt_without_req", 32'(gnt & ~req), 32'd0);
        if (!en)
            chk("gnt_when_en0", 32'(gnt), 32'd0);
        if (locked)
            chk("gnt_non_owner", 32'(gnt & ~own_mask), 32'd0);
    endtask

    task automatic apply(input logic [3:0] r, input logic [3:0] o, input logic [3:0] l, input logic e);
        @(negedge clk);
        req = r;
        ocy = o;
        rel = l;
        en  = e;
        #1;
        check_inv();
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] o, input logic [3:0] l, input logic e,
                       input logic [3:0] g, input logic [1:0] i, input logic lk, input logic [1:0] ow);
        vec_t v;
        v.req = r; v.ocy = o; v.rel = l; v.en = e;
        v.gnt = g; v.idx = i; v.locked = lk; v.owner = ow;
        tbl.push_back(v);
    endtask

    initial begin
        int pulses;
        int first_pulse;

        // round-robin fairness
        for (int k = 0; k < 8; k++)
            add(4'hF, 4'h0, 4'h0, 1'b1, 4'b0001 << (k % 4), 2'(k % 4), 1'b0, 2'd0);
        // wrap and skip
        add(4'b0100, 4'h0, 4'h0, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0);
        add(4'b0101, 4'h0, 4'h0, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0);
        add(4'b0101, 4'h0, 4'h0, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0);
        // backpressure
        for (int k = 0; k < 5; k++)
            add(4'b0011, 4'h0, 4'h0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0);
        add(4'b0011, 4'h0, 4'h0, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0);
        // ocy from a non-granted agent has no effect
        add(4'b0001, 4'b0010, 4'h0, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0);
        add(4'hF,    4'h0,    4'h0, 1'b1, 4'b0010, 2'd1, 1'b0, 2'd0);
        // lock on agent 2, masking, release
        add(4'b0100, 4'b0100, 4'h0,    1'b1, 4'b0100, 2'd2, 1'b0, 2'd0);
        add(4'hF,    4'h0,    4'h0,    1'b1, 4'b0100, 2'd2, 1'b1, 2'd2);
        add(4'hF,    4'h0,    4'b0001, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2);
        add(4'hF,    4'h0,    4'h0,    1'b0, 4'b0000, 2'd0, 1'b1, 2'd2);
        add(4'b1011, 4'h0,    4'h0,    1'b1, 4'b0000, 2'd0, 1'b1, 2'd2);
        add(4'hF,    4'hF,    4'h0,    1'b1, 4'b0100, 2'd2, 1'b1, 2'd2);
        add(4'hF,    4'h0,    4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2);
        add(4'hF,    4'h0,    4'h0,    1'b1, 4'b1000, 2'd3, 1'b0, 2'd0);
        // single-beat lock
        add(4'b0010, 4'b0010, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b0, 2'd0);
        add(4'hF,    4'h0,    4'h0,    1'b1, 4'b0100, 2'd2, 1'b0, 2'd0);

        // reset state
        rst = 1'b1; req = 4'hF; ocy = 4'h0; rel = 4'h0; en = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_gnt_idx", 32'(gnt_idx), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_to_pulse", 32'(to_pulse), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = 4'h0;

        foreach (tbl[i]) begin
            apply(tbl[i].req, tbl[i].ocy, tbl[i].rel, tbl[i].en);
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("vec%0d_idx", i), 32'(gnt_idx), 32'(tbl[i].idx));
            chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(tbl[i].locked));
            if (tbl[i].locked)
                chk($sformatf("vec%0d_owner", i), 32'(lock_owner), 32'(tbl[i].owner));
        end

        // reset while locked on agent 0 (ptr is 3 here)
        apply(4'b0001, 4'b0001, 4'h0, 1'b1);
        chk("lk0_gnt", 32'(gnt), 32'b0001);
        apply(4'hF, 4'h0, 4'h0, 1'b1);
        chk("lk0_locked", 32'(locked), 32'd1);
        chk("lk0_owner", 32'(lock_owner), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_to_pulse", 32'(to_pulse), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst_gnt_ptr0", 32'(gnt), 32'b0001);
        chk("postrst_locked", 32'(locked), 32'd0);

        // lock on agent 1, then owner stops requesting
        apply(4'b0010, 4'b0010, 4'h0, 1'b1);
        chk("lk1_gnt", 32'(gnt), 32'b0010);
        pulses      = 0;
        first_pulse = 0;
`ifdef XSW_ARB_LOCK_TIMEOUT_EN
        for (int c = 1; c <= 24; c++) begin
            apply((c == 16) ? 4'b0010 : 4'b0000, 4'h0, 4'h0, 1'b1);
            if (c == 16) begin
                chk("to_window_gnt", 32'(gnt), 32'd0);
                chk("to_window_locked", 32'(locked), 32'd1);
            end
            if (to_pulse) begin
                pulses++;
                if (first_pulse == 0)
                    first_pulse = c;
            end
        end
        chk("to_pulse_count", 32'(pulses), 32'd1);
        chk("to_pulse_cycle", 32'(first_pulse), 32'd17);
        chk("to_unlocked", 32'(locked), 32'd0);
`else
        for (int c = 1; c <= 100; c++) begin
            apply(4'b0000, 4'h0, 4'h0, 1'b1);
            if (to_pulse)
                pulses++;
        end
        chk("no_to_pulse", 32'(pulses), 32'd0);
        chk("still_locked", 32'(locked), 32'd1);
        chk("still_owner", 32'(lock_owner), 32'd1);
        apply(4'b0010, 4'h0, 4'b0010, 1'b1);
        chk("rel1_gnt", 32'(gnt), 32'b0010);
`endif
        apply(4'hF, 4'h0, 4'h0, 1'b1);
        chk("after_lk1_gnt", 32'(gnt), 32'b0100);
        chk("after_lk1_locked", 32'(locked), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
